// File: rtl/note_ascii_serializer_pkg.sv
// Shared note codes, ASCII constants and FSM states for the note text serializer.
// FLAT_NOTATION_EN selects flat spelling of accidentals inside note_char_lut.
package note_text_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_CS   = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_DS   = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_FS   = 4'd7;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_GS   = 4'd9;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_AS   = 4'd11;
  localparam logic [3:0] NOTE_B    = 4'd12;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_POUND   = 8'h23;
  localparam logic [7:0] ASCII_LOWER_B = 8'h62;
  localparam logic [7:0] ASCII_QMARK   = 8'h3F;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_A       = 8'h41;
  localparam logic [7:0] ASCII_B       = 8'h42;
  localparam logic [7:0] ASCII_C       = 8'h43;
  localparam logic [7:0] ASCII_D       = 8'h44;
  localparam logic [7:0] ASCII_E       = 8'h45;
  localparam logic [7:0] ASCII_F       = 8'h46;
  localparam logic [7:0] ASCII_G       = 8'h47;

  // Byte position within a channel; POS_SEP is the separator slot.
  localparam logic [1:0] POS_LETTER = 2'd0;
  localparam logic [1:0] POS_ACC    = 2'd1;
  localparam logic [1:0] POS_DIGIT  = 2'd2;
  localparam logic [1:0] POS_SEP    = 2'd3;

  typedef enum logic {IDLE, EMIT} state_t;

endpackage

// File: rtl/note_ascii_serializer_if.sv
// Byte stream (valid/ready/last) from the serializer to a text sink.
interface note_ascii_serializer_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       char_last;

  modport master (output char_out, output char_valid, output char_last, input char_ready);
  modport slave  (input char_out, input char_valid, input char_last, output char_ready);
endinterface

// File: rtl/note_ascii_serializer_char_lut.sv
// Combinational map from (note code, octave, byte position) to one ASCII byte.
// FLAT_NOTATION_EN renders accidentals as flats of the next letter up.
module note_char_lut
  import note_text_pkg::*;
#(
  parameter int OCT_W = 3
) (
  input  logic [3:0]       i_code,
  input  logic [OCT_W-1:0] i_octave,
  input  logic [1:0]       i_pos,
  output logic [7:0]       o_byte
);

  logic [7:0] w_letter;
  logic [7:0] w_acc;
  logic [7:0] w_digit;
  logic       w_rest;

  always_comb begin
    w_letter = ASCII_SPACE;
    w_acc    = ASCII_SPACE;
    w_rest   = 1'b0;
    case (i_code)
      NOTE_C:  w_letter = ASCII_C;
      NOTE_D:  w_letter = ASCII_D;
      NOTE_E:  w_letter = ASCII_E;
      NOTE_F:  w_letter = ASCII_F;
      NOTE_G:  w_letter = ASCII_G;
      NOTE_A:  w_letter = ASCII_A;
      NOTE_B:  w_letter = ASCII_B;
`ifdef FLAT_NOTATION_EN
      NOTE_CS: begin w_letter = ASCII_D; w_acc = ASCII_LOWER_B; end
      NOTE_DS: begin w_letter = ASCII_E; w_acc = ASCII_LOWER_B; end
      NOTE_FS: begin w_letter = ASCII_G; w_acc = ASCII_LOWER_B; end
      NOTE_GS: begin w_letter = ASCII_A; w_acc = ASCII_LOWER_B; end
      NOTE_AS: begin w_letter = ASCII_B; w_acc = ASCII_LOWER_B; end
`else
      NOTE_CS: begin w_letter = ASCII_C; w_acc = ASCII_POUND; end
      NOTE_DS: begin w_letter = ASCII_D; w_acc = ASCII_POUND; end
      NOTE_FS: begin w_letter = ASCII_F; w_acc = ASCII_POUND; end
      NOTE_GS: begin w_letter = ASCII_G; w_acc = ASCII_POUND; end
      NOTE_AS: begin w_letter = ASCII_A; w_acc = ASCII_POUND; end
`endif
      NOTE_REST: w_rest = 1'b1;
      default:   w_rest = 1'b1;
    endcase
  end

  // Octaves above 9 have no single digit, so they print as '?'.
  assign w_digit = (int'(i_octave) > 9) ? ASCII_QMARK : (ASCII_ZERO + 8'(i_octave));

  always_comb begin
    o_byte = ASCII_SPACE;
    if (!w_rest) begin
      case (i_pos)
        POS_LETTER: o_byte = w_letter;
        POS_ACC:    o_byte = w_acc;
        POS_DIGIT:  o_byte = w_digit;
        default:    o_byte = ASCII_SPACE;
      endcase
    end
  end

endmodule

// File: rtl/note_ascii_serializer.sv
// Snapshots NUM_CHANNELS notes/octaves on start and streams them as ASCII text.
// Build option FLAT_NOTATION_EN (see note_char_lut) switches to flat spelling.
module note_ascii_serializer
  import note_text_pkg::*;
#(
  parameter int         NUM_CHANNELS = 4,
  parameter int         OCT_W        = 3,
  parameter logic [7:0] SEP_CHAR     = 8'h7C
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [4*NUM_CHANNELS-1:0]     i_notes,
  input  logic [OCT_W*NUM_CHANNELS-1:0] i_octaves,
  output logic                          o_busy,
  note_ascii_serializer_if.master       char_if
);

  localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHANNELS - 1);

  state_t                        r_state, w_state_next;
  logic [CHAN_W-1:0]             r_chan_idx, w_chan_next;
  logic [1:0]                    r_pos_idx, w_pos_next;
  logic [4*NUM_CHANNELS-1:0]     r_notes;
  logic [OCT_W*NUM_CHANNELS-1:0] r_octaves;
  logic                          w_load;

  logic [3:0]       w_codes [NUM_CHANNELS];
  logic [OCT_W-1:0] w_octs  [NUM_CHANNELS];
  logic [7:0]       w_lut_byte;
  logic             w_valid;
  logic             w_last;
  logic             w_accept;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      assign w_codes[gi] = r_notes[4*gi +: 4];
      assign w_octs[gi]  = r_octaves[OCT_W*gi +: OCT_W];
    end
  endgenerate

  note_char_lut #(.OCT_W(OCT_W)) u_lut (
    .i_code   (w_codes[r_chan_idx]),
    .i_octave (w_octs[r_chan_idx]),
    .i_pos    (r_pos_idx),
    .o_byte   (w_lut_byte)
  );

  // All outputs decode from registers, so reset clears them without waiting for a clock.
  assign w_valid  = (r_state == EMIT);
  assign w_last   = w_valid && (r_chan_idx == LAST_CHAN) && (r_pos_idx == POS_DIGIT);
  assign w_accept = w_valid && char_if.char_ready;

  assign o_busy             = w_valid;
  assign char_if.char_valid = w_valid;
  assign char_if.char_last  = w_last;
  assign char_if.char_out   = !w_valid ? ASCII_SPACE :
                              (r_pos_idx == POS_SEP) ? SEP_CHAR : w_lut_byte;

  always_comb begin
    w_state_next = r_state;
    w_chan_next  = r_chan_idx;
    w_pos_next   = r_pos_idx;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = EMIT;
          w_chan_next  = '0;
          w_pos_next   = POS_LETTER;
          w_load       = 1'b1;
        end
      end
      EMIT: begin
        if (w_accept) begin
          if (w_last) begin
            w_state_next = IDLE;
            w_chan_next  = '0;
            w_pos_next   = POS_LETTER;
          end else if (r_pos_idx == POS_SEP) begin
            w_chan_next = r_chan_idx + CHAN_W'(1);
            w_pos_next  = POS_LETTER;
          end else begin
            w_pos_next = r_pos_idx + 2'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_chan_idx <= '0;
      r_pos_idx  <= '0;
      r_notes    <= '0;
      r_octaves  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_chan_idx <= w_chan_next;
      r_pos_idx  <= w_pos_next;
      if (w_load) begin
        r_notes   <= i_notes;
        r_octaves <= i_octaves;
      end
    end
  end

endmodule

// File: tb/tb_note_ascii_serializer.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor checks the stream.
module tb_note_ascii_serializer;

  localparam int NCH = 4;
  localparam int OW  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [4*NCH-1:0]  notes = '0;
  logic [OW*NCH-1:0] octaves = '0;
  logic              busy;

  note_ascii_serializer_if bus ();

  note_ascii_serializer #(.NUM_CHANNELS(NCH), .OCT_W(OW), .SEP_CHAR(8'h7C)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (start),
    .i_notes   (notes),
    .i_octaves (octaves),
    .o_busy    (busy),
    .char_if   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  // Monitor: pops on every accepted byte and checks stability across stalls.
  logic       stall_pending = 1'b0;
  logic [7:0] stall_byte;
  logic       stall_last;
  always @(negedge clk) begin
    if (!reset && bus.char_valid) begin
      if (stall_pending) begin
        checks++;
        if (bus.char_out !== stall_byte || bus.char_last !== stall_last) begin
          errors++;
          $display("FAIL stall_hold: got %02h last=%0b, expected %02h last=%0b",
                   bus.char_out, bus.char_last, stall_byte, stall_last);
        end
      end
      if (bus.char_ready) begin
        stall_pending = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte: got %02h last=%0b, expected no byte", bus.char_out, bus.char_last);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if (bus.char_out !== e[7:0] || bus.char_last !== e[8]) begin
            errors++;
            $display("FAIL byte: got %02h last=%0b, expected %02h last=%0b",
                     bus.char_out, bus.char_last, e[7:0], e[8]);
          end else begin
            $display("byte %02h '%c' last=%0b ok", bus.char_out, bus.char_out, bus.char_last);
          end
        end
      end else begin
        stall_pending = 1'b1;
        stall_byte    = bus.char_out;
        stall_last    = bus.char_last;
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++)
      exp_q.push_back({(i == s.len() - 1), s[i]});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end else begin
      $display("check %s = %0h ok", name, got);
    end
  endtask

  // Called at posedge+1; pulses start and runs until busy drops.
  task automatic run_frame(input bit toggle, input bit repulse, input int exp_busy);
    int cyc;
    int busy_cnt;
    logic [3:0] pat;
    pat = 4'b1001;
    cyc = 0;
    busy_cnt = 0;
    bus.char_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 200 && busy) begin
      busy_cnt++;
      bus.char_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (repulse && cyc == 4) begin
        start = 1'b1;
        notes = {NCH{4'd9}};
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    bus.char_ready = 1'b1;
    check("frame_done_in_time", {31'd0, busy}, 32'd0);
    if (exp_busy >= 0) check("busy_cycles", busy_cnt, exp_busy);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  string f1, fg, fa, fb, ff;

  initial begin
`ifdef FLAT_NOTATION_EN
    f1 = "C 4|Db4|   |B 5";
    fg = "Ab4|Ab4|Ab0|Ab5";
    fb = "A ?|B 9|   |Bb0";
    ff = "Db3|Eb3|Gb3|Bb3";
`else
    f1 = "C 4|C#4|   |B 5";
    fg = "G#4|G#4|G#0|G#5";
    fb = "A ?|B 9|   |A#0";
    ff = "C#3|D#3|F#3|A#3";
`endif
    fa = "   |   |   |E ?";
    bus.char_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, bus.char_valid}, 32'd0);
    check("reset_last",  {31'd0, bus.char_last}, 32'd0);
    check("reset_char",  {24'd0, bus.char_out}, 32'h20);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic frame at full throughput.
    notes   = {4'd12, 4'd0, 4'd2, 4'd1};
    octaves = {4'd5, 4'd0, 4'd4, 4'd4};
    push_str(f1);
    run_frame(1'b0, 1'b0, 15);

    // Ready pattern 1,0,0,1.
    push_str(f1);
    run_frame(1'b1, 1'b0, -1);

    // Start re-pulsed mid-frame with changed notes: must be ignored.
    push_str(f1);
    run_frame(1'b0, 1'b1, 15);

    // Fresh start picks up the all-9 notes.
    push_str(fg);
    run_frame(1'b0, 1'b0, 15);

    // Reset at byte 7 aborts the frame.
    notes = {4'd12, 4'd0, 4'd2, 4'd1};
    push_str(f1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_valid", {31'd0, bus.char_valid}, 32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_char",  {24'd0, bus.char_out}, 32'h20);
    check("abort_bytes_left", exp_q.size(), 32'd8);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    push_str(f1);
    run_frame(1'b0, 1'b0, 15);

    // Out-of-range codes and octaves.
    notes   = {4'd5, 4'd15, 4'd14, 4'd13};
    octaves = {4'd12, 4'd3, 4'd3, 4'd12};
    push_str(fa);
    run_frame(1'b0, 1'b0, 15);

    notes   = {4'd11, 4'd0, 4'd12, 4'd10};
    octaves = {4'd0, 4'd0, 4'd9, 4'd12};
    push_str(fb);
    run_frame(1'b1, 1'b0, -1);

    // Accidental spelling.
    notes   = {4'd11, 4'd7, 4'd4, 4'd2};
    octaves = 16'h3333;
    push_str(ff);
    run_frame(1'b0, 1'b0, 15);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_ascii_serializer.md
Name: note_ascii_serializer

Overview:
Multi-channel successor to the single-note ASCII translator. It snapshots NUM_CHANNELS 4-bit note codes plus their octave numbers on a start pulse. It then streams the formatted text (letter, accidental, octave digit, separator) one byte per handshake to the character display / UART text path. A valid/ready byte interface with a last flag replaces the old fixed 16-bit combinational output.

Parameters:
NUM_CHANNELS, 4, number of note channels formatted per frame (1..16)
OCT_W, 3, width of each octave field; octave value 0..9 is printed as a digit
SEP_CHAR, 8'h7C, ASCII byte emitted between channels ('|'); never emitted after the last channel

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to format the current inputs; ignored while busy
notes  input  4*NUM_CHANNELS  note codes; channel i is notes[4*i+3:4*i]; channel 0 is emitted first
octaves  input  OCT_W*NUM_CHANNELS  octave per channel, same packing as notes
busy  output  1  high from the cycle after an accepted start until the last byte is accepted
char_out  output  8  current ASCII byte
char_valid  output  1  char_out is valid
char_ready  input  1  sink accepts char_out this cycle when char_valid is high
char_last  output  1  high with the final byte of the frame

Behaviour:
- Reset (asynchronous, active-high) forces: busy=0, char_valid=0, char_last=0, char_out=8'h20, state=IDLE, counters=0. Snapshot registers are cleared to rest/0.
- Note code map: 0 rest; 1 C; 2 C#; 3 D; 4 D#; 5 E; 6 F; 7 F#; 8 G; 9 G#; 10 A; 11 A#; 12 B. Codes 13-15 are treated as rest.
- Per channel, 3 bytes are emitted in this order:
  - letter;
  - accidental ('#' or space);
  - octave digit (8'h30+octave).
  - A rest emits three spaces.
  - An octave value >9 prints '?' (8'h3F).
- SEP_CHAR is emitted after every channel except the last. Frame length = 4*NUM_CHANNELS-1 bytes.
- FSM states:
  - IDLE: start=1 latches notes/octaves into snapshot registers and moves to EMIT.
  - EMIT: presents the byte for {chan_idx, pos_idx}; advances only on char_valid&&char_ready.
  - After the last byte is accepted, returns to IDLE.
- Latency: char_valid rises the cycle after an accepted start. busy rises on the same edge. busy and char_valid fall on the edge where the last byte is accepted.
- Handshake rules:
  - char_out and char_last are held stable while char_valid && !char_ready.
  - char_valid never drops mid-frame.
  - Throughput is one byte per cycle with ready held high.
- Inputs may change freely after start; only the snapshot is formatted. start during busy is dropped, with no queueing.
- Counter widths: pos_idx is 2 bits (0..3, where 3 = separator). chan_idx is $clog2(NUM_CHANNELS), minimum 1 bit. No wrap beyond NUM_CHANNELS-1.
- NUM_CHANNELS=1: frame is exactly 3 bytes; no separator.
- Reset asserted mid-frame: the frame is aborted immediately, with no partial completion. The next start begins a fresh frame at channel 0.
- Any byte driven while char_valid=0 is don't-care to the sink. It is still driven to space for waveform readability.

Optional Feature:
FLAT_NOTATION_EN:
- Defined: accidentals render as the flat of the next letter up, with 'b' (8'h62) as the accidental byte. Mapping: 2 "Db", 4 "Eb", 7 "Gb", 9 "Ab", 11 "Bb". Naturals are unchanged.
- Undefined: sharp notation per the map above.
- Frame length is identical in both builds.

Decomposition:
- Package note_text_pkg holds:
  - note code localparams (NOTE_REST..NOTE_B);
  - ASCII constants (ASCII_SPACE, ASCII_POUND, ASCII_LOWER_B, ASCII_QMARK, ASCII_ZERO, letters A-G);
  - FSM state enum (IDLE, EMIT).
- One combinational sub-module note_char_lut: inputs code[3:0], octave[OCT_W-1:0], pos[1:0]; output byte[7:0]. Contains the map and the FLAT_NOTATION_EN branch.
- The top module holds the FSM, snapshot registers, counters and handshake.

Test Plan:
- NUM_CHANNELS=4, notes={12,0,2,1}, octaves={5,0,4,4}, ready=1, start pulse -> 15 bytes "C 4|C#4|   |B 5". char_last is on byte 15. busy is high for 15 cycles.
- Same frame with ready toggling 1,0,0,1 -> identical byte sequence. char_out is stable across every stall cycle. No byte is duplicated or skipped.
- start re-pulsed at byte 5, and notes changed to all 9 mid-frame -> frame unchanged. After completion a new start emits "G#…".
- Reset asserted at byte 7 -> char_valid=0, busy=0 asynchronously. Next start restarts at "C".
- Codes 13,14,15 and octave 12 on channel 0 -> three spaces for codes; octave digit '?' for any valid note with octave 12.
- FLAT_NOTATION_EN build, notes={11,7,4,2}, octaves=3 -> "Db3|Eb3|Gb3|Bb3".
